pipelined_adder: RTL and testbench

- Parametrised successor to the team's fixed-width combinational adder.
- Computes a+b+cin or a-b-cin on WIDTH-bit operands.
- The carry chain is split into STAGES registered segments, so wide adds close timing.
- Valid/ready handshakes on input and output; sits between operand-producing logic and any downstream consumer that may apply backpressure.

---
 rtl/pipelined_adder_if.sv | 27 ++
 rtl/pipelined_adder.sv | 106 ++++++++++
 tb/tb_pipelined_adder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The slave side is the adder; the master side is whoever feeds and drains it.
interface pipelined_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// Add/subtract with the carry chain cut into STAGES registered segments.
// The whole pipeline freezes while the head result is stalled by the consumer.
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  pipelined_adder_if.slave bus
);
  localparam int SEG = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_adder: WIDTH must be >= 2, STAGES >= 1 and WIDTH divisible by STAGES");
  end

  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] carry_p;
  logic [STAGES-1:0] op_p;
  logic [WIDTH-1:0]  a_p   [STAGES];
  logic [WIDTH-1:0]  bx_p  [STAGES];
  logic [WIDTH-1:0]  sum_p [STAGES];

  logic [STAGES-1:0] vld_n;
  logic [STAGES-1:0] carry_n;
  logic [STAGES-1:0] op_n;
  logic [WIDTH-1:0]  a_n   [STAGES];
  logic [WIDTH-1:0]  bx_n  [STAGES];
  logic [WIDTH-1:0]  sum_n [STAGES];

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Subtraction is a + ~b + !cin; the final carry is inverted back into a borrow.
  assign b_eff   = bus.op ? ~bus.b : bus.b;
  assign cin_eff = bus.op ? ~bus.cin : bus.cin;

  assign stall        = vld_p[STAGES-1] & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}}) << (k * SEG);

    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] bx_in;
    logic [WIDTH-1:0] s_in;
    logic             c_in;
    logic             op_in;
    logic             v_in;
    logic [SEG:0]     seg_add;

    if (k == 0) begin : g_first
      assign a_in  = bus.a;
      assign bx_in = b_eff;
      assign s_in  = '0;
      assign c_in  = cin_eff;
      assign op_in = bus.op;
      assign v_in  = bus.in_valid;
    end else begin : g_next
      assign a_in  = a_p[k-1];
      assign bx_in = bx_p[k-1];
      assign s_in  = sum_p[k-1];
      assign c_in  = carry_p[k-1];
      assign op_in = op_p[k-1];
      assign v_in  = vld_p[k-1];
    end

    assign seg_add = {1'b0, a_in[k*SEG +: SEG]} + {1'b0, bx_in[k*SEG +: SEG]}
                   + {{SEG{1'b0}}, c_in};

    assign a_n[k]     = a_in;
    assign bx_n[k]    = bx_in;
    assign sum_n[k]   = (s_in & ~SEG_MASK) | (WIDTH'(seg_add[SEG-1:0]) << (k * SEG));
    assign carry_n[k] = seg_add[SEG];
    assign op_n[k]    = op_in;
    assign vld_n[k]   = v_in;
  end

  // Stage registers: stage k holds the sum through segment k and its carry-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p   <= '0;
      carry_p <= '0;
      op_p    <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_p[k]   <= '0;
        bx_p[k]  <= '0;
        sum_p[k] <= '0;
      end
    end else if (!stall) begin
      vld_p   <= vld_n;
      carry_p <= carry_n;
      op_p    <= op_n;
      a_p     <= a_n;
      bx_p    <= bx_n;
      sum_p   <= sum_n;
    end
  end

  assign bus.out_valid = vld_p[STAGES-1];
  assign bus.sum       = sum_p[STAGES-1];
  assign bus.cout      = carry_p[STAGES-1] ^ op_p[STAGES-1];
  assign bus.ovf       = (a_p[STAGES-1][WIDTH-1] == bx_p[STAGES-1][WIDTH-1])
                       & (sum_p[STAGES-1][WIDTH-1] != a_p[STAGES-1][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed vectors on 8-bit configs plus a
// randomized scoreboard across several WIDTH/STAGES combinations.
module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit start_rand = 1'b0;
  int done_cnt = 0;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          tag;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       op;
    logic [7:0] s;
    logic       c;
    logic       v;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic op);
    exp_t   e;
    longint m, ua, ub, sa, sb, ru, rs;
    m  = longint'(1) << w;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (!op) begin
      ru = ua + ub + longint'(cin);
      rs = sa + sb + longint'(cin);
      e.cout = (ru >= m);
    end else begin
      ru = ua - ub - longint'(cin);
      rs = sa - sb - longint'(cin);
      e.cout = (ru < 0);
    end
    e.sum = 32'(ru & (m - 1));
    e.ovf = (rs >= m / 2) || (rs < -(m / 2));
    e.tag = 0;
    return e;
  endfunction

  pipelined_adder_if #(.WIDTH(8)) bus0 ();
  pipelined_adder #(.WIDTH(8), .STAGES(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  pipelined_adder_if #(.WIDTH(8)) bus1 ();
  pipelined_adder #(.WIDTH(8), .STAGES(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  for (genvar gi = 0; gi < 8; gi++) begin : g_rand
    localparam int W = (gi < 4) ? 8 : 32;
    localparam int S = 1 << (gi % 4);
    pipelined_adder_if #(.WIDTH(W)) bus ();
    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    initial begin : drive
      exp_t q[$];
      exp_t e;
      int   adv;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.op = 1'b0;
      wait (start_rand);
      adv = 0;
      for (int c = 0; c < 400 + S + 4; c++) begin
        @(negedge clk);
        if (c < 400) begin
          bus.in_valid  = ($urandom_range(0, 3) != 0);
          bus.out_ready = ($urandom_range(0, 3) != 0);
          case ($urandom_range(0, 5))
            0: bus.a = '1;
            1: bus.a = W'(1) << (W - 1);
            default: bus.a = W'($urandom);
          endcase
          bus.b   = ($urandom_range(0, 5) == 0) ? '1 : W'($urandom);
          bus.cin = 1'($urandom);
          bus.op  = 1'($urandom);
        end else begin
          bus.in_valid  = 1'b0;
          bus.out_ready = 1'b1;
        end
        #1;
        if (bus.out_valid) begin
          if (q.size() == 0) chk($sformatf("r%0d_spurious_valid", gi), 64'(bus.out_valid), 64'd0);
          else if (bus.out_ready) begin
            e = q.pop_front();
            chk($sformatf("r%0d_sum", gi), 64'(bus.sum), 64'(e.sum));
            chk($sformatf("r%0d_cout", gi), 64'(bus.cout), 64'(e.cout));
            chk($sformatf("r%0d_ovf", gi), 64'(bus.ovf), 64'(e.ovf));
            chk($sformatf("r%0d_latency", gi), 64'(adv - e.tag), 64'(S));
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          e = model(W, 32'(bus.a), 32'(bus.b), bus.cin, bus.op);
          e.tag = adv;
          q.push_back(e);
        end
        if (!bus.out_valid || bus.out_ready) adv++;
      end
      chk($sformatf("r%0d_drained", gi), 64'(q.size()), 64'd0);
      done_cnt++;
    end
  end

  vec_t vecs[10];

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    bus0.in_valid = 1'b1; bus0.a = v.a; bus0.b = v.b; bus0.cin = v.cin; bus0.op = v.op;
    bus0.out_ready = 1'b1;
    #1 chk($sformatf("vec%0d_in_ready", idx), 64'(bus0.in_ready), 64'd1);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    lat = 1;
    while (!bus0.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("vec%0d_latency", idx), 64'(lat), 64'd2);
    chk($sformatf("vec%0d_sum", idx), 64'(bus0.sum), 64'(v.s));
    chk($sformatf("vec%0d_cout", idx), 64'(bus0.cout), 64'(v.c));
    chk($sformatf("vec%0d_ovf", idx), 64'(bus0.ovf), 64'(v.v));
  endtask

  initial begin
    int sent, got, first_c, last_c, lat;
    bit held;
    logic [7:0] held_sum;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1};
    vecs[9] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1};

    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0; bus0.op = 1'b0;
    bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.op = 1'b0;
    bus1.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    chk("rst_sum", 64'(bus0.sum), 64'd0);
    chk("rst_cout", 64'(bus0.cout), 64'd0);
    chk("rst_ovf", 64'(bus0.ovf), 64'd0);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", 64'(bus0.in_ready), 64'd1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Stream of 10 adds with a 3-cycle consumer stall in the middle.
    sent = 0; got = 0; first_c = -1; last_c = -1; held = 1'b0; held_sum = '0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      @(negedge clk);
      bus0.out_ready = !(c >= 6 && c < 9);
      bus0.in_valid  = (sent < 10);
      bus0.a   = 8'(sent);
      bus0.b   = 8'(2 * sent);
      bus0.cin = sent[0];
      bus0.op  = 1'b0;
      #1;
      if (bus0.out_valid && !bus0.out_ready) begin
        chk("stall_in_ready", 64'(bus0.in_ready), 64'd0);
        if (held) chk("stall_head_stable", 64'(bus0.sum), 64'(held_sum));
        held_sum = bus0.sum;
        held = 1'b1;
      end else held = 1'b0;
      if (bus0.out_valid && bus0.out_ready) begin
        chk($sformatf("stream%0d_sum", got), 64'(bus0.sum), 64'(3 * got + (got % 2)));
        chk($sformatf("stream%0d_cout", got), 64'(bus0.cout), 64'd0);
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      if (bus0.in_valid && bus0.in_ready) sent++;
    end
    bus0.in_valid = 1'b0;
    chk("stream_count", 64'(got), 64'd10);
    chk("stream_span", 64'(last_c - first_c), 64'd12);

    // STAGES=4 subtract with borrow-in and signed overflow.
    @(negedge clk);
    bus1.in_valid = 1'b1; bus1.a = 8'h80; bus1.b = 8'h01; bus1.cin = 1'b1; bus1.op = 1'b1;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    lat = 1;
    while (!bus1.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("s4_latency", 64'(lat), 64'd4);
    chk("s4_sum", 64'(bus1.sum), 64'h7E);
    chk("s4_cout", 64'(bus1.cout), 64'd0);
    chk("s4_ovf", 64'(bus1.ovf), 64'd1);

    // Asynchronous reset with two transactions in flight.
    @(negedge clk);
    bus0.out_ready = 1'b1;
    bus0.in_valid = 1'b1; bus0.a = 8'h7F; bus0.b = 8'h01; bus0.cin = 1'b0; bus0.op = 1'b0;
    @(negedge clk);
    bus0.a = 8'h10; bus0.b = 8'h20;
    @(negedge clk);
    bus0.in_valid = 1'b0;
    chk("midrst_pre_valid", 64'(bus0.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus0.out_valid), 64'd0);
    chk("midrst_sum", 64'(bus0.sum), 64'd0);
    chk("midrst_cout", 64'(bus0.cout), 64'd0);
    chk("midrst_ovf", 64'(bus0.ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midrst_in_ready", 64'(bus0.in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("midrst_no_stale%0d", i), 64'(bus0.out_valid), 64'd0);
    end

    start_rand = 1'b1;
    for (int t = 0; t < 3000 && done_cnt < 8; t++) @(negedge clk);
    chk("rand_done", 64'(done_cnt), 64'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
